mem_bist: RTL and testbench

- Parametrised memory built-in self-test engine. Drives a single-port memory controller through its request/ready handshake (mem/rw/address/data_in, ready/data_out style).
- Runs one or all of several data patterns over the full address space, counting mismatches and capturing the first failure.
- Sits between the board-level sequencer and the RAM controller, replacing hard-wired write-all/read-all test loops.
- Generalises those loops in address width, data width, pattern selection, first-fail capture and abort.

---
 rtl/mem_bist_pkg.sv | 25 ++
 rtl/mem_bist_if.sv | 31 +++
 rtl/mem_bist_pattern.sv | 38 +++
 rtl/mem_bist.sv | 186 ++++++++++++++++++
 tb/tb_mem_bist.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg
// Shared types and constants for the memory BIST engine: the sequencer
// state encoding, the mode codes accepted on the mode input and the
// pattern indices reported on fail_pat.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_TURN,
        S_READ,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_ADDR = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_CHK  = 2'd2;
    localparam logic [1:0] MODE_ALL  = 2'd3;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_INV   = 2'd1;
    localparam logic [1:0] PAT_CHK   = 2'd2;

endpackage

// File: rtl/mem_bist_if.sv
// mem_bist_if
// Request/ready handshake between the BIST engine and a single-port
// memory controller.
//   mem_req   : access request, held until mem_ready
//   mem_rw    : 0 = write, 1 = read
//   mem_addr  : access address
//   mem_wdata : write data
//   mem_ready : one-cycle pulse, access complete
//   mem_rdata : read data, valid with mem_ready
// master = BIST side, slave = controller side.
interface mem_bist_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_rw, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_rw, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_bist_pattern.sv
// mem_bist_pattern
// Combinational test-pattern generator.
//   pat  : pattern index (0 addr, 1 ~addr, 2 checkerboard)
//   addr : memory address
//   data : pattern word for that address
// The address is resized to DATA_W before inversion, so ~addr has its
// upper bits set when DATA_W > ADDR_W.
module mem_bist_pattern
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
) (
    input  logic [1:0]        pat,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] addr_ext;

    assign addr_ext = DATA_W'(addr);

    // Checkerboard: even addresses get ...1010, odd addresses ...0101.
    always_comb begin
        data = '0;
        case (pat)
            PAT_ADDR: data = addr_ext;
            PAT_INV:  data = ~addr_ext;
            PAT_CHK: begin
                for (int i = 0; i < DATA_W; i++) begin
                    data[i] = addr[0] ^ (i % 2 == 1);
                end
            end
            default:  data = '0;
        endcase
    end

endmodule

// File: rtl/mem_bist.sv
// mem_bist
// Memory built-in self-test engine. Writes a pattern over the whole
// address space, reads it back and compares, optionally for all three
// patterns in sequence.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : pulse, honoured in IDLE or DONE
//   abort       : level, returns to IDLE keeping results
//   mode        : 0 addr, 1 ~addr, 2 checker, 3 all three
//   mem_if      : request/ready bus to the memory controller
//   busy, done  : activity / completion status
//   pass        : done with zero mismatches
//   err_count   : saturating mismatch count
//   fail_*      : first-mismatch capture (address, data, pattern)
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    mem_bist_if.master        mem_if,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [1:0]        fail_pat
);

    state_t            state;
    logic [1:0]        mode_q;
    logic [1:0]        pat;
    logic [1:0]        pat_n;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] pat_data;
    logic [DATA_W-1:0] exp_q;
    logic              req;
    logic              rw;
    logic              last_addr;

    assign last_addr = (addr == {ADDR_W{1'b1}});

    // Next address/pattern. The pattern generator sees these next values
    // so its result can be registered into exp_q; exp_q then always
    // matches the current addr/pat and serves both as registered write
    // data and as the read comparator's reference.
    always_comb begin
        addr_n = addr;
        pat_n  = pat;
        if (!abort) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr_n = '0;
                        pat_n  = (mode == MODE_ALL) ? PAT_ADDR : mode;
                    end
                end
                S_WRITE, S_READ: begin
                    if (mem_if.mem_ready) addr_n = addr + ADDR_W'(1);
                end
                S_NEXT: begin
                    if (mode_q == MODE_ALL && pat < PAT_CHK) pat_n = pat + 2'd1;
                end
                default: ;
            endcase
        end
    end

    mem_bist_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern (
        .pat  (pat_n),
        .addr (addr_n),
        .data (pat_data)
    );

    // Sequencer. abort wins over start and mem_ready; in IDLE it simply
    // keeps the engine idle. The final read's compare lands on the same
    // edge that enters NEXT, so pass is computed in NEXT from a complete
    // count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            mode_q     <= MODE_ADDR;
            pat        <= PAT_ADDR;
            addr       <= '0;
            exp_q      <= '0;
            req        <= 1'b0;
            rw         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
            fail_pat   <= '0;
        end else begin
            addr  <= addr_n;
            pat   <= pat_n;
            exp_q <= pat_data;
            if (abort) begin
                state <= S_IDLE;
                req   <= 1'b0;
                busy  <= 1'b0;
                done  <= 1'b0;
                pass  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            mode_q     <= mode;
                            err_count  <= '0;
                            fail_valid <= 1'b0;
                            fail_addr  <= '0;
                            fail_data  <= '0;
                            fail_pat   <= '0;
                            state      <= S_WRITE;
                            req        <= 1'b1;
                            rw         <= 1'b0;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            pass       <= 1'b0;
                        end
                    end
                    S_WRITE: begin
                        if (mem_if.mem_ready && last_addr) begin
                            req   <= 1'b0;
                            state <= S_TURN;
                        end
                    end
                    S_TURN: begin
                        state <= S_READ;
                        req   <= 1'b1;
                        rw    <= 1'b1;
                    end
                    S_READ: begin
                        if (mem_if.mem_ready) begin
                            if (mem_if.mem_rdata != exp_q) begin
                                if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
                                if (!fail_valid) begin
                                    fail_valid <= 1'b1;
                                    fail_addr  <= addr;
                                    fail_data  <= mem_if.mem_rdata;
                                    fail_pat   <= pat;
                                end
                            end
                            if (last_addr) begin
                                req   <= 1'b0;
                                state <= S_NEXT;
                            end
                        end
                    end
                    S_NEXT: begin
                        if (mode_q == MODE_ALL && pat < PAT_CHK) begin
                            state <= S_WRITE;
                            req   <= 1'b1;
                            rw    <= 1'b0;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == '0);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign mem_if.mem_req   = req;
    assign mem_if.mem_rw    = rw;
    assign mem_if.mem_addr  = addr;
    assign mem_if.mem_wdata = exp_q;

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist
// Bench for mem_bist with ADDR_W=4, DATA_W=8. Two engines share one RAM
// model: dut_a (ERR_W=8) for most scenarios and dut_s (ERR_W=2) for
// counter saturation; sel picks which one the model serves. Expected
// accesses are queued when a run is started and checked as the model
// accepts each one; end-of-run results are checked against fixed values.
module tb_mem_bist;
    import mem_bist_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_s, abort;
    logic [1:0] mode;

    always #5 clk = ~clk;

    mem_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    mem_bist_if #(.ADDR_W(AW), .DATA_W(DW)) bus_s ();

    logic          busy_a, done_a, pass_a, fv_a;
    logic [EW-1:0] err_a;
    logic [AW-1:0] fa_a;
    logic [DW-1:0] fd_a;
    logic [1:0]    fp_a;
    logic          busy_s, done_s, pass_s, fv_s;
    logic [1:0]    err_s;
    logic [AW-1:0] fa_s;
    logic [DW-1:0] fd_s;
    logic [1:0]    fp_s;

    mem_bist #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(EW)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort), .mode(mode),
        .mem_if(bus_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_valid(fv_a), .fail_addr(fa_a),
        .fail_data(fd_a), .fail_pat(fp_a)
    );

    mem_bist #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(2)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .abort(abort), .mode(mode),
        .mem_if(bus_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_count(err_s), .fail_valid(fv_s), .fail_addr(fa_s),
        .fail_data(fd_s), .fail_pat(fp_s)
    );

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    acc_t          sb[$];
    logic [DW-1:0] ram [0:15];
    int            vectors = 0;
    int            miscompares = 0;
    bit            sel = 0;
    bit            fault_en = 0;
    bit            zero_all = 0;
    bit            rdy = 0;
    int            cnt = 0;
    int            n_wr, n_rd, n_gap;

    function automatic logic [DW-1:0] exp_pat(input int p, input int a);
        logic [DW-1:0] v;
        v = DW'(a);
        case (p)
            0: return v;
            1: return ~v;
            default: return (a % 2 == 0) ? 8'hAA : 8'h55;
        endcase
    endfunction

    // Queue every access one run of mode m should issue, in order.
    task automatic push_run(input int m);
        int first, last;
        first = (m == 3) ? 0 : m;
        last  = (m == 3) ? 2 : m;
        for (int p = first; p <= last; p++) begin
            for (int a = 0; a < 16; a++) sb.push_back('{1'b0, AW'(a), exp_pat(p, a)});
            for (int a = 0; a < 16; a++) sb.push_back('{1'b1, AW'(a), 8'h00});
        end
    endtask

    task automatic clear_model();
        rdy = 0;
        cnt = 0;
        bus_a.mem_ready = 1'b0;
        bus_s.mem_ready = 1'b0;
        bus_a.mem_rdata = '0;
        bus_s.mem_rdata = '0;
        sb.delete();
    endtask

    task automatic kick(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        push_run(int'(m));
        if (sel) start_s = 1'b1;
        else start_a = 1'b1;
        n_wr = 0;
        n_rd = 0;
        n_gap = 0;
    endtask

    // Runs the RAM model one cycle per negedge until the selected engine
    // reports done, or until it presents (trig_rw, trig_addr), in which
    // case trig_hit is set and the caller acts. Ready comes two cycles
    // after a request is first seen.
    task automatic run(input int budget, input int trig_rw, input int trig_addr, output bit trig_hit);
        logic req, rw, dn, bz;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, rd;
        acc_t e;
        trig_hit = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_s = 1'b0;
            req  = sel ? bus_s.mem_req   : bus_a.mem_req;
            rw   = sel ? bus_s.mem_rw    : bus_a.mem_rw;
            addr = sel ? bus_s.mem_addr  : bus_a.mem_addr;
            wd   = sel ? bus_s.mem_wdata : bus_a.mem_wdata;
            dn   = sel ? done_s : done_a;
            bz   = sel ? busy_s : busy_a;
            rd   = '0;
            if (dn) begin
                clear_model();
                return;
            end
            if (bz && !req) n_gap++;
            if (rdy) begin
                rdy = 0;
                cnt = 0;
            end else if (req) begin
                if (cnt == 1) begin
                    cnt = 0;
                    rdy = 1;
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("[TB] FAIL access: unexpected rw=%0d addr=%0h, scoreboard empty", rw, addr);
                    end else begin
                        e = sb.pop_front();
                        if (rw !== e.rw || addr !== e.addr || (!rw && wd !== e.data)) begin
                            miscompares++;
                            $display("[TB] FAIL access: got rw=%0d addr=%0h wdata=%0h, want rw=%0d addr=%0h wdata=%0h",
                                     rw, addr, wd, e.rw, e.addr, e.data);
                        end
                    end
                    if (!rw) begin
                        ram[addr] = wd;
                        n_wr++;
                    end else begin
                        rd = ram[addr];
                        if (fault_en && addr == 4'd5) rd[0] = 1'b0;
                        if (zero_all) rd = '0;
                        n_rd++;
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
            if (sel) begin
                bus_s.mem_ready = rdy;
                bus_s.mem_rdata = rd;
            end else begin
                bus_a.mem_ready = rdy;
                bus_a.mem_rdata = rd;
            end
            if (!rdy && req && trig_rw >= 0 && int'(rw) == trig_rw && int'(addr) == trig_addr) begin
                trig_hit = 1;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL timeout: done not seen within %0d cycles", budget);
        clear_model();
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({busy_a, done_a, pass_a, fv_a, err_a, fa_a, fd_a, fp_a, bus_a.mem_req, bus_a.mem_rw,
             bus_a.mem_addr, bus_a.mem_wdata} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_a: got nonzero outputs, want all 0");
        end
        vectors++;
        if ({busy_s, done_s, pass_s, fv_s, err_s, bus_s.mem_req} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_s: got nonzero outputs, want all 0");
        end
    endtask

    task automatic test_clean();
        bit hit;
        kick(MODE_ADDR);
        run(2000, -1, 0, hit);
        vectors++;
        if ({done_a, pass_a, fv_a, err_a} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            miscompares++;
            $display("[TB] FAIL clean_result: got done=%0d pass=%0d fv=%0d err=%0d, want 1 1 0 0",
                     done_a, pass_a, fv_a, err_a);
        end
        vectors++;
        if (n_wr !== 16 || n_rd !== 16 || n_gap !== 2 || sb.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL clean_seq: got wr=%0d rd=%0d idle=%0d left=%0d, want 16 16 2 0",
                     n_wr, n_rd, n_gap, sb.size());
        end
    endtask

    task automatic test_fault();
        bit hit;
        fault_en = 1;
        kick(MODE_ADDR);
        run(2000, -1, 0, hit);
        vectors++;
        if ({done_a, pass_a, fv_a, err_a} !== {1'b1, 1'b0, 1'b1, 8'd1}) begin
            miscompares++;
            $display("[TB] FAIL fault_result: got done=%0d pass=%0d fv=%0d err=%0d, want 1 0 1 1",
                     done_a, pass_a, fv_a, err_a);
        end
        vectors++;
        if (fa_a !== 4'd5 || fd_a !== 8'h04 || fp_a !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL fault_capture: got addr=%0h data=%0h pat=%0d, want 5 04 0", fa_a, fd_a, fp_a);
        end
    endtask

    task automatic test_all_modes();
        bit hit;
        fault_en = 1;
        kick(MODE_ALL);
        run(4000, -1, 0, hit);
        fault_en = 0;
        vectors++;
        if ({done_a, pass_a, err_a} !== {1'b1, 1'b0, 8'd2}) begin
            miscompares++;
            $display("[TB] FAIL all_result: got done=%0d pass=%0d err=%0d, want 1 0 2", done_a, pass_a, err_a);
        end
        vectors++;
        if (fa_a !== 4'd5 || fd_a !== 8'h04 || fp_a !== 2'd0 || fv_a !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL all_capture: got addr=%0h data=%0h pat=%0d fv=%0d, want 5 04 0 1",
                     fa_a, fd_a, fp_a, fv_a);
        end
        vectors++;
        if (n_wr !== 48 || n_rd !== 48 || n_gap !== 6 || sb.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL all_seq: got wr=%0d rd=%0d idle=%0d left=%0d, want 48 48 6 0",
                     n_wr, n_rd, n_gap, sb.size());
        end
    endtask

    task automatic test_saturate();
        bit hit;
        sel = 1;
        zero_all = 1;
        kick(MODE_INV);
        run(2000, -1, 0, hit);
        vectors++;
        if ({done_s, pass_s, fv_s, err_s} !== {1'b1, 1'b0, 1'b1, 2'd3}) begin
            miscompares++;
            $display("[TB] FAIL sat_result: got done=%0d pass=%0d fv=%0d err=%0d, want 1 0 1 3",
                     done_s, pass_s, fv_s, err_s);
        end
        vectors++;
        if (fa_s !== 4'd0 || fd_s !== 8'h00 || fp_s !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL sat_capture: got addr=%0h data=%0h pat=%0d, want 0 00 1", fa_s, fd_s, fp_s);
        end
        zero_all = 0;
        sel = 0;
    endtask

    task automatic test_abort();
        bit hit;
        kick(MODE_ADDR);
        run(2000, 0, 7, hit);
        vectors++;
        if (hit !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL abort_reach: got hit=%0d, want 1", hit);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if ({bus_a.mem_req, busy_a, done_a, pass_a} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL abort_state: got req=%0d busy=%0d done=%0d pass=%0d, want 0 0 0 0",
                     bus_a.mem_req, busy_a, done_a, pass_a);
        end
        clear_model();
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus_a.mem_req, busy_a} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: got req=%0d busy=%0d, want 0 0", bus_a.mem_req, busy_a);
        end
        kick(MODE_ADDR);
        run(2000, -1, 0, hit);
        vectors++;
        if ({done_a, pass_a, err_a, sb.size() == 0} !== {1'b1, 1'b1, 8'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL abort_rerun: got done=%0d pass=%0d err=%0d left=%0d, want 1 1 0 0",
                     done_a, pass_a, err_a, sb.size());
        end
    endtask

    task automatic test_midread_reset();
        bit hit;
        fault_en = 1;
        kick(MODE_ADDR);
        run(2000, 1, 9, hit);
        fault_en = 0;
        vectors++;
        if (hit !== 1'b1 || err_a !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL rst_reach: got hit=%0d err=%0d, want 1 1", hit, err_a);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy_a, done_a, pass_a, fv_a, err_a, fa_a, fd_a, fp_a, bus_a.mem_req, bus_a.mem_rw,
             bus_a.mem_addr, bus_a.mem_wdata} !== '0) begin
            miscompares++;
            $display("[TB] FAIL rst_async: got busy=%0d req=%0d err=%0d fv=%0d addr=%0h, want all 0",
                     busy_a, bus_a.mem_req, err_a, fv_a, bus_a.mem_addr);
        end
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        kick(MODE_ADDR);
        run(2000, -1, 0, hit);
        vectors++;
        if ({done_a, pass_a, fv_a, err_a, n_wr == 16, n_rd == 16} !== {1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL rst_rerun: got done=%0d pass=%0d err=%0d wr=%0d rd=%0d, want 1 1 0 16 16",
                     done_a, pass_a, err_a, n_wr, n_rd);
        end
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_s = 1'b0;
        abort   = 1'b0;
        mode    = 2'd0;
        clear_model();
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_clean();
        test_fault();
        test_all_modes();
        test_saturate();
        test_abort();
        test_midread_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
